// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } hz_state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_LOAD = 2'b01;
   localparam logic [1:0] CAUSE_HILO = 2'b10;
   localparam logic [1:0] CAUSE_BOTH = 2'b11;

   // Counter width able to hold max_value, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

   function automatic bit params_legal(input int unsigned load_use_stall,
                                       input int unsigned branch_flush_slots,
                                       input int unsigned muldiv_latency);
      return (load_use_stall >= 1) && (load_use_stall <= 4) &&
             (branch_flush_slots >= 1) && (branch_flush_slots <= 3) &&
             (muldiv_latency <= 64);
   endfunction

endpackage

// File: rtl/hazard_countdown.sv
// Loadable down-counter that saturates at zero.
module hazard_countdown
   import hazard_pkg::*;
#(
   parameter int unsigned MAX_VALUE = 1,
   parameter int unsigned W         = cnt_w(MAX_VALUE)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              value <= '0;
      else if (load)          value <= load_value;
      else if (value != '0)   value <= value - W'(1);
   end

   assign zero = (value == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use, HI/LO and branch/jump hazard control for the 5-stage MIPS pipeline.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W         = 5,
   parameter int unsigned LOAD_USE_STALL     = 1,
   parameter int unsigned BRANCH_FLUSH_SLOTS = 1,
   parameter int unsigned MULDIV_LATENCY     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Branch,
   input  logic                  Jump,
   input  logic                  ID_EX_MemRead,
   input  logic [REG_ADDR_W-1:0] ID_EX_Rt_Reg,
   input  logic [REG_ADDR_W-1:0] IF_ID_Rs_Reg,
   input  logic [REG_ADDR_W-1:0] IF_ID_Rt_Reg,
   input  logic                  IF_ID_Uses_Rt,
   input  logic                  ID_EX_MulDiv_Start,
   input  logic                  IF_ID_Reads_HiLo,
   output logic                  Stall,
   output logic                  Flush,
   output logic                  Block_PC_Write,
   output logic                  Block_IF_ID_Write,
   output logic                  MulDiv_Busy,
   output logic [1:0]            Stall_Cause
);

   localparam int unsigned LD_W = cnt_w(LOAD_USE_STALL);
   localparam int unsigned MD_W = cnt_w(MULDIV_LATENCY);
   localparam int unsigned FL_W = cnt_w(BRANCH_FLUSH_SLOTS);

   if (!params_legal(LOAD_USE_STALL, BRANCH_FLUSH_SLOTS, MULDIV_LATENCY)) begin : g_bad_params
      $error("hazard_control_unit: parameter out of legal range");
   end

   hz_state_t       state;
   logic [LD_W-1:0] ld_cnt;
   logic [MD_W-1:0] md_cnt;
   logic [FL_W-1:0] fl_cnt;
   logic            ld_zero, md_zero, fl_zero;
   logic            lu_hit, load_stall, hilo_stall, stall_c, branch_evt;
   logic            unused_cnt;

   // Wrong-path instructions behind a taken branch never raise a load-use stall.
   assign lu_hit = (state == ST_RUN) && fl_zero && ID_EX_MemRead &&
                   (ID_EX_Rt_Reg != '0) &&
                   ((ID_EX_Rt_Reg == IF_ID_Rs_Reg) ||
                    (IF_ID_Uses_Rt && (ID_EX_Rt_Reg == IF_ID_Rt_Reg)));

   assign load_stall = (state == ST_LOAD_WAIT) || lu_hit;
   assign hilo_stall = (MULDIV_LATENCY != 0) && IF_ID_Reads_HiLo &&
                       (!md_zero || ID_EX_MulDiv_Start);
   assign stall_c    = load_stall || hilo_stall;
   assign branch_evt = (Branch || Jump) && !stall_c;
   assign unused_cnt = ^{md_cnt, fl_cnt};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:
               if (lu_hit && (LOAD_USE_STALL > 1)) state <= ST_LOAD_WAIT;
            ST_LOAD_WAIT:
               if (ld_zero || (ld_cnt == LD_W'(1))) state <= ST_RUN;
            default:
               state <= ST_RUN;
         endcase
      end
   end

   hazard_countdown #(.MAX_VALUE(LOAD_USE_STALL)) u_ld_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       ((state == ST_RUN) && lu_hit && (LOAD_USE_STALL > 1)),
      .load_value (LD_W'(LOAD_USE_STALL - 1)),
      .value      (ld_cnt),
      .zero       (ld_zero)
   );

   hazard_countdown #(.MAX_VALUE(MULDIV_LATENCY)) u_md_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (ID_EX_MulDiv_Start && (MULDIV_LATENCY != 0)),
      .load_value (MD_W'(MULDIV_LATENCY)),
      .value      (md_cnt),
      .zero       (md_zero)
   );

   hazard_countdown #(.MAX_VALUE(BRANCH_FLUSH_SLOTS)) u_fl_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (branch_evt),
      .load_value (FL_W'(BRANCH_FLUSH_SLOTS - 1)),
      .value      (fl_cnt),
      .zero       (fl_zero)
   );

   // Outputs are forced low for the whole time reset is held.
   always_comb begin
      Stall             = 1'b0;
      Flush             = 1'b0;
      MulDiv_Busy       = 1'b0;
      Stall_Cause       = CAUSE_NONE;
      if (!reset) begin
         Stall       = stall_c;
         Flush       = branch_evt || !fl_zero;
         MulDiv_Busy = !md_zero;
         Stall_Cause = (load_stall ? CAUSE_LOAD : CAUSE_NONE) |
                       (hilo_stall ? CAUSE_HILO : CAUSE_NONE);
      end
      Block_PC_Write    = Stall;
      Block_IF_ID_Write = Stall;
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a cycle-indexed reference model.
module tb_hazard_control_unit;

   localparam int unsigned LUS = 2;
   localparam int unsigned BFS = 2;
   localparam int unsigned MDL = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       Branch, Jump, ID_EX_MemRead, IF_ID_Uses_Rt;
   logic       ID_EX_MulDiv_Start, IF_ID_Reads_HiLo;
   logic [4:0] ID_EX_Rt_Reg, IF_ID_Rs_Reg, IF_ID_Rt_Reg;
   logic       Stall, Flush, Block_PC_Write, Block_IF_ID_Write, MulDiv_Busy;
   logic [1:0] Stall_Cause;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_control_unit #(
      .REG_ADDR_W(5), .LOAD_USE_STALL(LUS),
      .BRANCH_FLUSH_SLOTS(BFS), .MULDIV_LATENCY(MDL)
   ) dut (
      .clk(clk), .reset(reset), .Branch(Branch), .Jump(Jump),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt_Reg(ID_EX_Rt_Reg),
      .IF_ID_Rs_Reg(IF_ID_Rs_Reg), .IF_ID_Rt_Reg(IF_ID_Rt_Reg),
      .IF_ID_Uses_Rt(IF_ID_Uses_Rt), .ID_EX_MulDiv_Start(ID_EX_MulDiv_Start),
      .IF_ID_Reads_HiLo(IF_ID_Reads_HiLo), .Stall(Stall), .Flush(Flush),
      .Block_PC_Write(Block_PC_Write), .Block_IF_ID_Write(Block_IF_ID_Write),
      .MulDiv_Busy(MulDiv_Busy), .Stall_Cause(Stall_Cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: hazards expressed as the last cycle each effect stays active.
   int cyc    = 0;
   int ld_end = -100;
   int md_end = -100;
   int fl_end = -100;

   always @(negedge clk) begin
      bit lu, e_load, e_busy, e_hilo, e_stall, br, e_flush;
      lu = 0; e_load = 0; e_busy = 0; e_hilo = 0; e_stall = 0; br = 0; e_flush = 0;
      if (reset) begin
         ld_end = -100; md_end = -100; fl_end = -100;
      end else begin
         lu = !(cyc <= ld_end) && (cyc > fl_end) && ID_EX_MemRead &&
              (ID_EX_Rt_Reg != 0) &&
              ((ID_EX_Rt_Reg == IF_ID_Rs_Reg) ||
               (IF_ID_Uses_Rt && (ID_EX_Rt_Reg == IF_ID_Rt_Reg)));
         e_load  = (cyc <= ld_end) || lu;
         e_busy  = (cyc <= md_end);
         e_hilo  = (MDL != 0) && IF_ID_Reads_HiLo && (e_busy || ID_EX_MulDiv_Start);
         e_stall = e_load || e_hilo;
         br      = (Branch || Jump) && !e_stall;
         e_flush = br || (cyc <= fl_end);
      end
      chk("stall",       {1'b0, Stall},             {1'b0, e_stall});
      chk("block_pc",    {1'b0, Block_PC_Write},    {1'b0, e_stall});
      chk("block_ifid",  {1'b0, Block_IF_ID_Write}, {1'b0, e_stall});
      chk("flush",       {1'b0, Flush},             {1'b0, e_flush});
      chk("muldiv_busy", {1'b0, MulDiv_Busy},       {1'b0, e_busy});
      chk("stall_cause", Stall_Cause,               {e_hilo, e_load});
      if (!reset) begin
         if (lu) ld_end = cyc + int'(LUS) - 1;
         if (ID_EX_MulDiv_Start && MDL != 0) md_end = cyc + int'(MDL);
         if (br) fl_end = cyc + int'(BFS) - 1;
      end
      cyc++;
   end

   // Apply one cycle of inputs shortly after the rising edge.
   task automatic drive(input logic br, input logic jmp, input logic mr,
                        input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic st, input logic rd);
      @(posedge clk);
      #1;
      Branch = br; Jump = jmp; ID_EX_MemRead = mr; ID_EX_Rt_Reg = ex_rt;
      IF_ID_Rs_Reg = rs; IF_ID_Rt_Reg = rt; IF_ID_Uses_Rt = urt;
      ID_EX_MulDiv_Start = st; IF_ID_Reads_HiLo = rd;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      Branch = 0; Jump = 0; ID_EX_MemRead = 0; ID_EX_Rt_Reg = '0;
      IF_ID_Rs_Reg = '0; IF_ID_Rt_Reg = '0; IF_ID_Uses_Rt = 0;
      ID_EX_MulDiv_Start = 0; IF_ID_Reads_HiLo = 0;

      // hazard presented while reset is held must not show
      drive(1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1);
      chk("lit_reset_stall", {1'b0, Stall}, 2'd0);
      chk("lit_reset_flush", {1'b0, Flush}, 2'd0);
      idle();
      reset = 1'b0;
      idle();
      chk("lit_post_reset_busy", {1'b0, MulDiv_Busy}, 2'd0);

      // load-use on rs: two stall cycles
      drive(0, 0, 1, 5'd8, 5'd8, 5'd3, 1, 0, 0);
      chk("lit_lu_stall0", {1'b0, Stall}, 2'd1);
      chk("lit_lu_cause0", Stall_Cause, 2'b01);
      idle();
      chk("lit_lu_stall1", {1'b0, Stall}, 2'd1);
      idle();
      chk("lit_lu_stall2", {1'b0, Stall}, 2'd0);

      // $zero and unused rt never stall; used rt does
      drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      chk("lit_zero_reg", {1'b0, Stall}, 2'd0);
      drive(0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
      chk("lit_rt_unused", {1'b0, Stall}, 2'd0);
      drive(0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
      chk("lit_rt_used", {1'b0, Stall}, 2'd1);
      idle();
      idle();

      // mult/div start then mflo two cycles later
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      idle();
      chk("lit_busy_t1", {1'b0, MulDiv_Busy}, 2'd1);
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      chk("lit_hilo_cause", Stall_Cause, 2'b10);
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      chk("lit_hilo_t4", {1'b0, Stall}, 2'd1);
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      chk("lit_hilo_t5_stall", {1'b0, Stall}, 2'd0);
      chk("lit_hilo_t5_busy", {1'b0, MulDiv_Busy}, 2'd0);
      idle();

      // restart while busy extends the busy window
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      idle();
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      for (int i = 0; i < 4; i++) idle();
      chk("lit_rebusy_last", {1'b0, MulDiv_Busy}, 2'd1);
      idle();
      chk("lit_rebusy_done", {1'b0, MulDiv_Busy}, 2'd0);

      // branch flushes two slots; load-use on the wrong path is ignored
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      chk("lit_br_flush0", {1'b0, Flush}, 2'd1);
      drive(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
      chk("lit_br_flush1", {1'b0, Flush}, 2'd1);
      chk("lit_br_nostall", {1'b0, Stall}, 2'd0);
      idle();
      chk("lit_br_flush2", {1'b0, Flush}, 2'd0);

      // branch during a load stall waits for the stall to clear
      drive(1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
      chk("lit_brst_stall", {1'b0, Stall}, 2'd1);
      chk("lit_brst_flush", {1'b0, Flush}, 2'd0);
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      chk("lit_brst_reflush", {1'b0, Flush}, 2'd1);
      idle();
      idle();

      // jump flush
      drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      chk("lit_jump_flush", {1'b0, Flush}, 2'd1);
      idle();
      idle();

      // load-use and HI/LO stalls overlap
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      drive(0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1);
      chk("lit_both_cause", Stall_Cause, 2'b11);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      idle();

      // reset during load wait, busy and flush aborts everything
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      drive(0, 0, 1, 5'd7, 5'd0, 5'd7, 1, 0, 0);
      @(posedge clk);
      #1;
      Branch = 0; ID_EX_MemRead = 0; IF_ID_Uses_Rt = 0;
      reset = 1'b1;
      #1;
      chk("lit_rst_mid_stall", {1'b0, Stall}, 2'd0);
      chk("lit_rst_mid_busy", {1'b0, MulDiv_Busy}, 2'd0);
      idle();
      reset = 1'b0;
      idle();
      chk("lit_after_rst_stall", {1'b0, Stall}, 2'd0);
      chk("lit_after_rst_busy", {1'b0, MulDiv_Busy}, 2'd0);
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      @(posedge clk);
      #1;
      Branch = 0;
      reset = 1'b1;
      #1;
      chk("lit_rst_mid_flush", {1'b0, Flush}, 2'd0);
      idle();
      reset = 1'b0;
      idle();
      chk("lit_after_rst_flush", {1'b0, Flush}, 2'd0);
      idle();
      idle();

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
